evaluate_request: RTL

- Requester/collector side of the evaluator interface.
- Accepts a board from the search core and drives the `board_valid`/`board`/`clear_eval`/`white_to_move` inputs of an evaluator.
- Waits for `eval_valid`, then blends `eval_mg`/`eval_eg` into one side-to-move-relative tapered score.
- Returns that score to the search core over a valid/ready handshake, with a watchdog for a stalled evaluator.

---
 rtl/evaluate_request.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/evaluate_request.sv
// Requester/collector for the position evaluator: hands a board to the evaluator,
// tapers the returned mg/eg scores by game phase and returns a side-to-move score.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module evaluate_request #(
  parameter int EVAL_WIDTH = 24,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [`BOARD_WIDTH-1:0]       req_board,
  input  logic                          req_white_to_move,
  input  logic [4:0]                    req_phase,
  output logic                          board_valid,
  output logic [`BOARD_WIDTH-1:0]       board,
  output logic                          clear_eval,
  output logic                          white_to_move,
  input  logic                          eval_valid,
  input  logic signed [EVAL_WIDTH-1:0]  eval_mg,
  input  logic signed [EVAL_WIDTH-1:0]  eval_eg,
  input  logic                          insufficient_material,
  output logic                          score_valid,
  input  logic                          score_ready,
  output logic signed [EVAL_WIDTH-1:0]  score,
  output logic                          score_draw,
  output logic                          timeout_err
);

  localparam int TW  = EVAL_WIDTH + 6;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  // Symmetric saturation bounds so negating a saturated score is always representable.
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    BLEND  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                        state_q;
  logic [WDW-1:0]                wd_q;
  logic [4:0]                    phase_q;
  logic signed [EVAL_WIDTH-1:0]  mg_q;
  logic signed [EVAL_WIDTH-1:0]  eg_q;
  logic                          insuf_q;

  logic [4:0]                    phase_clamp_s;
  logic signed [TW-1:0]          mg_ext_s;
  logic signed [TW-1:0]          eg_ext_s;
  logic signed [TW-1:0]          ph_ext_s;
  logic signed [TW-1:0]          ph_inv_s;
  logic signed [TW-1:0]          tapered_s;
  logic signed [TW-1:0]          shifted_s;
  logic signed [TW-1:0]          oriented_s;
  logic signed [EVAL_WIDTH-1:0]  blend_s;

  // Phase clamp: anything above 16 counts as pure middlegame.
  always_comb begin
    if (req_phase > 5'd16) begin
      phase_clamp_s = 5'd16;
    end else begin
      phase_clamp_s = req_phase;
    end
  end

  // Tapered blend of the captured scores, oriented to side to move and saturated.
  always_comb begin
    mg_ext_s  = {{(TW-EVAL_WIDTH){mg_q[EVAL_WIDTH-1]}}, mg_q};
    eg_ext_s  = {{(TW-EVAL_WIDTH){eg_q[EVAL_WIDTH-1]}}, eg_q};
    ph_ext_s  = {{(TW-5){1'b0}}, phase_q};
    ph_inv_s  = {{(TW-5){1'b0}}, 5'd16 - phase_q};
    tapered_s = (mg_ext_s * ph_ext_s) + (eg_ext_s * ph_inv_s);
    shifted_s = tapered_s >>> 4;
    if (!white_to_move) begin
      oriented_s = -shifted_s;
    end else begin
      oriented_s = shifted_s;
    end
    if (oriented_s > SAT_MAX) begin
      blend_s = SAT_MAX[EVAL_WIDTH-1:0];
    end else if (oriented_s < SAT_MIN) begin
      blend_s = SAT_MIN[EVAL_WIDTH-1:0];
    end else begin
      blend_s = oriented_s[EVAL_WIDTH-1:0];
    end
  end

  // Request/evaluate/blend/output sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      phase_q       <= 5'd0;
      mg_q          <= '0;
      eg_q          <= '0;
      insuf_q       <= 1'b0;
      req_ready     <= 1'b1;
      board_valid   <= 1'b0;
      board         <= '0;
      clear_eval    <= 1'b0;
      white_to_move <= 1'b1;
      score_valid   <= 1'b0;
      score         <= '0;
      score_draw    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      clear_eval <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            board         <= req_board;
            white_to_move <= req_white_to_move;
            phase_q       <= phase_clamp_s;
            req_ready     <= 1'b0;
            board_valid   <= 1'b1;
            wd_q          <= '0;
            state_q       <= WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          // A response arriving on the last watchdog cycle still wins.
          if (eval_valid) begin
            mg_q        <= eval_mg;
            eg_q        <= eval_eg;
            insuf_q     <= insufficient_material;
            board_valid <= 1'b0;
            clear_eval  <= 1'b1;
            state_q     <= BLEND;
          end else if (wd_q == WD_LAST) begin
            board_valid <= 1'b0;
            clear_eval  <= 1'b1;
            score       <= '0;
            score_draw  <= 1'b0;
            timeout_err <= 1'b1;
            score_valid <= 1'b1;
            state_q     <= OUTPUT;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        BLEND: begin
          if (insuf_q) begin
            score      <= '0;
            score_draw <= 1'b1;
          end else begin
            score      <= blend_s;
            score_draw <= 1'b0;
          end
          timeout_err <= 1'b0;
          score_valid <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (score_ready) begin
            score_valid <= 1'b0;
            req_ready   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            score_valid <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready   <= 1'b1;
          board_valid <= 1'b0;
          score_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
